// File: rtl/param_scheduler_if.sv
// Handshake bundle between the sequencing FSM and the parameter scheduler.
interface param_scheduler_if #(
  parameter int N_PARAM = 16,
  parameter int IDX_W   = 4
);
  logic [2:0]         state;
  logic               start_req;
  logic [N_PARAM-1:0] init_mask;
  logic               wb_valid;
  logic               wb_done;
  logic               is_start;
  logic               is_find;
  logic               is_finish;
  logic [IDX_W-1:0]   param_idx;
  logic [7:0]         sweep_cnt;
  logic               timeout;

  modport master (
    output state, start_req, init_mask, wb_valid, wb_done,
    input  is_start, is_find, is_finish, param_idx, sweep_cnt, timeout
  );

  modport slave (
    input  state, start_req, init_mask, wb_valid, wb_done,
    output is_start, is_find, is_finish, param_idx, sweep_cnt, timeout
  );
endinterface

// File: rtl/param_scheduler.sv
// Round-robin scheduler over a pending-parameter bitmap; produces the start/find/finish
// strobes that steer the top-level sequencing FSM.
module param_scheduler #(
  parameter int N_PARAM   = 16,
  parameter int IDX_W     = 4,
  parameter int MAX_SWEEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  param_scheduler_if.slave  bus
);
  localparam logic [2:0]       S_IDLE       = 3'd0;
  localparam logic [2:0]       S_GET_PARAM  = 3'd1;
  localparam logic [2:0]       S_WRITE_BACK = 3'd5;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_PARAM - 1);
  localparam logic [7:0]       MAX_SW       = 8'(MAX_SWEEP);

  logic [N_PARAM-1:0] r_pending;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_param_idx;
  logic [7:0]         r_sweep_cnt;
  logic               r_armed;
  logic               r_is_start;
  logic               r_is_find;
  logic               r_is_finish;
  logic               r_timeout;

  logic               w_start;
  logic               w_live;
  logic               w_fin_empty;
  logic               w_fin_sweep;
  logic               w_finish;
  logic               w_scan;
  logic               w_hit;
  logic               w_wrap;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic               w_wb_clr;

  assign w_start     = bus.start_req && (bus.state == S_IDLE) && !r_is_finish;
  assign w_live      = r_armed && !r_is_finish;
  // Finish looks at the registered bitmap, so a write-back clear is seen one edge later.
  assign w_fin_empty = w_live && (r_pending == '0);
  assign w_fin_sweep = w_live && (r_pending != '0) && (r_sweep_cnt >= MAX_SW);
  assign w_finish    = w_fin_empty || w_fin_sweep;
  // A scan step is suppressed whenever finish fires, so finish always beats find.
  assign w_scan      = (bus.state == S_GET_PARAM) && w_live && !r_is_find && !w_finish;
  assign w_hit       = r_pending[r_ptr];
  assign w_wrap      = w_scan && (r_ptr == LAST_IDX);
  assign w_ptr_nxt   = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
  assign w_wb_clr    = (bus.state == S_WRITE_BACK) && bus.wb_valid && bus.wb_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_ptr       <= '0;
      r_param_idx <= '0;
      r_sweep_cnt <= '0;
      r_armed     <= 1'b0;
      r_is_start  <= 1'b0;
      r_is_find   <= 1'b0;
      r_is_finish <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_start) begin
        r_pending   <= bus.init_mask;
        r_ptr       <= '0;
        r_sweep_cnt <= '0;
        r_armed     <= 1'b1;
        r_is_start  <= 1'b1;
      end else begin
        if (r_is_start && (bus.state != S_IDLE))
          r_is_start <= 1'b0;
        if (w_wb_clr)
          r_pending[r_param_idx] <= 1'b0;
        if (w_scan)
          r_ptr <= w_ptr_nxt;
        if (w_wrap && (r_sweep_cnt != 8'hFF))
          r_sweep_cnt <= r_sweep_cnt + 8'd1;
        if (w_finish)
          r_is_finish <= 1'b1;
        if (w_fin_sweep)
          r_timeout <= 1'b1;
      end

      if (w_scan && w_hit) begin
        r_is_find   <= 1'b1;
        r_param_idx <= r_ptr;
      end else begin
        r_is_find   <= 1'b0;
      end
    end
  end

  assign bus.is_start  = r_is_start;
  assign bus.is_find   = r_is_find;
  assign bus.is_finish = r_is_finish;
  assign bus.param_idx = r_param_idx;
  assign bus.sweep_cnt = r_sweep_cnt;
  assign bus.timeout   = r_timeout;
endmodule
